// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared definitions for the multi-port register file
package rf_pkg;

  localparam logic [0:0] RF_IDLE  = 1'b0;
  localparam logic [0:0] RF_CLEAR = 1'b1;

  function automatic int rf_aw(input int nregs);
    return (nregs <= 1) ? 1 : $clog2(nregs);
  endfunction

  // Bit offset of lane k in a packed bus of w-bit lanes.
  function automatic int rf_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port with zero check, busy mask and bypass
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]       ra_i,
  input  logic                busy_i,
  input  logic [XLEN-1:0]     arr_i,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   wa_i,
  input  logic [NWR*XLEN-1:0] wd_i,
  output logic [XLEN-1:0]     rd_o
);

  // we_i is already gated by reset/clear, so a match here is a winning write;
  // ascending scan lets the highest-index port override lower ones.
  always_comb begin
    rd_o = arr_i;
    if (BYPASS != 0) begin
      for (int k = 0; k < NWR; k++) begin
        if (we_i[k] && (wa_i[rf_lsb(k, AW) +: AW] == ra_i)) begin
          rd_o = wd_i[rf_lsb(k, XLEN) +: XLEN];
        end
      end
    end
    if (busy_i || (ra_i == '0)) begin
      rd_o = '0;
    end
  end

endmodule

// File: rtl/rf_mp.sv
// rtl/rf_mp.sv - multi-port register file: array, write priority, clear engine, debug tap
module rf_mp
  import rf_pkg::*;
#(
  parameter int  XLEN   = 32,
  parameter int  NREGS  = 32,
  parameter int  NRD    = 2,
  parameter int  NWR    = 2,
  parameter int  BYPASS = 1,
  localparam int AW     = rf_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic                busy,
  input  logic [AW-1:0]       dbg_sel,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [NWR-1:0]  we_ok;

  assign busy  = (state_q == RF_CLEAR);
  assign we_ok = (rst || busy) ? '0 : we;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == RF_CLEAR) begin
      if (ptr_q == AW'(NREGS - 1)) begin
        state_d = RF_IDLE;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + AW'(1);
      end
    end
  end

  // Later ports overwrite earlier ones, giving highest-index priority on collisions.
  always_comb begin
    mem_d = mem_q;
    if (state_q == RF_CLEAR) begin
      mem_d[ptr_q] = '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (we_ok[k] && (wa[rf_lsb(k, AW) +: AW] != '0)) begin
          mem_d[wa[rf_lsb(k, AW) +: AW]] = wd[rf_lsb(k, XLEN) +: XLEN];
        end
      end
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      ptr_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mem_q   <= mem_d;
    end
  end

  assign dbg_data = (dbg_sel == '0) ? '0 : mem_q[dbg_sel];

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0] ra_j;
    assign ra_j = ra[rf_lsb(j, AW) +: AW];

    rf_read_port #(
      .XLEN  (XLEN),
      .AW    (AW),
      .NWR   (NWR),
      .BYPASS(BYPASS)
    ) u_rd (
      .ra_i  (ra_j),
      .busy_i(busy),
      .arr_i (mem_q[ra_j]),
      .we_i  (we_ok),
      .wa_i  (wa),
      .wd_i  (wd),
      .rd_o  (rd[rf_lsb(j, XLEN) +: XLEN])
    );
  end

endmodule

// File: tb/tb_rf_mp.sv
// tb/tb_rf_mp.sv - directed scoreboard bench for rf_mp, bypass and non-bypass builds side by side
module tb_rf_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  localparam int S_RB0 = 0, S_RB1 = 1, S_RN0 = 2, S_RN1 = 3;
  localparam int S_DB = 4, S_DN = 5, S_BB = 6, S_BN = 7;

  logic                clk = 1'b0;
  logic                rst;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic [NRD*AW-1:0]   ra;
  logic [AW-1:0]       dbg_sel;
  logic [NRD*XLEN-1:0] rd_b, rd_n;
  logic                busy_b, busy_n;
  logic [XLEN-1:0]     dbg_b, dbg_n;

  always #5 clk = ~clk;

  rf_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b),
    .busy(busy_b), .dbg_sel(dbg_sel), .dbg_data(dbg_b)
  );

  rf_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nob (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_n),
    .busy(busy_n), .dbg_sel(dbg_sel), .dbg_data(dbg_n)
  );

  typedef struct {
    string           tag;
    int              src;
    logic [XLEN-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n;

  function automatic logic [XLEN-1:0] observe(input int src);
    case (src)
      S_RB0:   return rd_b[0 +: XLEN];
      S_RB1:   return rd_b[XLEN +: XLEN];
      S_RN0:   return rd_n[0 +: XLEN];
      S_RN1:   return rd_n[XLEN +: XLEN];
      S_DB:    return dbg_b;
      S_DN:    return dbg_n;
      S_BB:    return {31'b0, busy_b};
      default: return {31'b0, busy_n};
    endcase
  endfunction

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input string tag, input int src, input logic [XLEN-1:0] exp);
    exp_t e;
    e.tag = tag;
    e.src = src;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.src), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] addr, input logic [XLEN-1:0] data);
    we[port]               = 1'b1;
    wa[port*AW +: AW]      = addr;
    wd[port*XLEN +: XLEN]  = data;
  endtask

  task automatic idle();
    we = '0;
  endtask

  task automatic rdp(input int port, input logic [AW-1:0] addr);
    ra[port*AW +: AW] = addr;
  endtask

  // Counts edges until busy falls, checking that both read ports stay masked.
  task automatic wait_clear(output int edges);
    edges = 0;
    while (busy_b && edges < 100) begin
      expect_v("rd0_zero_busy", S_RB0, '0);
      expect_v("rd1_zero_busy", S_RB1, '0);
      expect_v("rdn0_zero_busy", S_RN0, '0);
      drain();
      tick();
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; we = '0; wa = '0; wd = '0; ra = '0; dbg_sel = '0;
    tick();
    tick();
    expect_v("busy_in_reset", S_BB, 32'd1);
    expect_v("busy_in_reset_nb", S_BN, 32'd1);
    drain();

    // Reset and clear: 31 edges, everything zero.
    rst = 1'b0;
    rdp(0, 5'd5);
    rdp(1, 5'd17);
    wait_clear(n);
    check("clear_edges", n, 32'd31);
    expect_v("busy_low", S_BB, '0);
    expect_v("busy_low_nb", S_BN, '0);
    drain();
    for (int a = 1; a < NREGS; a++) begin
      rdp(0, AW'(a));
      dbg_sel = AW'(a);
      #1;
      expect_v("clear_rd", S_RB0, '0);
      expect_v("clear_rd_nb", S_RN0, '0);
      expect_v("clear_dbg", S_DB, '0);
      drain();
    end

    // Write then read.
    wr(0, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    rdp(0, 5'd5);
    dbg_sel = 5'd5;
    #1;
    expect_v("x5_rd", S_RB0, 32'hDEADBEEF);
    expect_v("x5_rd_nb", S_RN0, 32'hDEADBEEF);
    expect_v("x5_dbg", S_DB, 32'hDEADBEEF);
    drain();

    wr(0, 5'd0, 32'h00001234);
    rdp(1, 5'd0);
    #1;
    expect_v("x0_bypass", S_RB1, '0);
    drain();
    tick();
    idle();
    rdp(0, 5'd0);
    dbg_sel = 5'd0;
    #1;
    expect_v("x0_rd", S_RB0, '0);
    expect_v("x0_dbg", S_DB, '0);
    expect_v("x0_dbg_nb", S_DN, '0);
    drain();

    // Collision: port 1 wins.
    wr(0, 5'd7, 32'h11111111);
    wr(1, 5'd7, 32'h22222222);
    tick();
    idle();
    rdp(0, 5'd7);
    #1;
    expect_v("collide", S_RB0, 32'h22222222);
    expect_v("collide_nb", S_RN0, 32'h22222222);
    drain();

    // Bypass versus old value.
    wr(1, 5'd7, 32'hA5A5A5A5);
    #1;
    expect_v("bypass", S_RB0, 32'hA5A5A5A5);
    expect_v("no_bypass_old", S_RN0, 32'h22222222);
    drain();
    tick();
    idle();
    #1;
    expect_v("after_wr", S_RB0, 32'hA5A5A5A5);
    expect_v("after_wr_nb", S_RN0, 32'hA5A5A5A5);
    drain();

    wr(0, 5'd8, 32'h0BADF00D);
    wr(1, 5'd9, 32'hC0FFEE01);
    rdp(0, 5'd8);
    rdp(1, 5'd9);
    #1;
    expect_v("bypass_p0", S_RB0, 32'h0BADF00D);
    expect_v("bypass_p1", S_RB1, 32'hC0FFEE01);
    expect_v("old_x8_nb", S_RN0, '0);
    expect_v("old_x9_nb", S_RN1, '0);
    drain();
    tick();
    idle();
    #1;
    expect_v("x8_nb", S_RN0, 32'h0BADF00D);
    expect_v("x9_nb", S_RN1, 32'hC0FFEE01);
    drain();

    wr(0, 5'd7, 32'h33333333);
    wr(1, 5'd7, 32'h44444444);
    rdp(0, 5'd7);
    #1;
    expect_v("bypass_prio", S_RB0, 32'h44444444);
    expect_v("bypass_prio_nb", S_RN0, 32'hA5A5A5A5);
    drain();
    tick();
    idle();

    // Mid-clear reset restarts; late write to x9 is lost.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rdp(0, 5'd5);
    rdp(1, 5'd9);
    for (int i = 0; i < 10; i++) tick();
    expect_v("busy_mid", S_BB, 32'd1);
    drain();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (busy_b && n < 100) begin
      if (n == 20) wr(0, 5'd9, 32'h000000FF);
      else idle();
      expect_v("rd_zero_midclear", S_RB1, '0);
      drain();
      tick();
      n++;
    end
    idle();
    check("midclear_edges", n, 32'd31);
    dbg_sel = 5'd9;
    #1;
    expect_v("x5_cleared", S_RB0, '0);
    expect_v("x9_lost", S_RB1, '0);
    expect_v("x9_lost_nb", S_RN1, '0);
    expect_v("x9_dbg", S_DB, '0);
    drain();

    // Reset-write race.
    wr(0, 5'd3, 32'h00000077);
    tick();
    idle();
    wr(0, 5'd3, 32'h00000055);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    expect_v("race_busy", S_BB, 32'd1);
    expect_v("race_busy_nb", S_BN, 32'd1);
    drain();
    rdp(0, 5'd3);
    wait_clear(n);
    check("race_clear_edges", n, 32'd31);
    dbg_sel = 5'd3;
    #1;
    expect_v("x3_rd", S_RB0, '0);
    expect_v("x3_dbg", S_DB, '0);
    expect_v("x3_dbg_nb", S_DN, '0);
    drain();

    // First write accepted right after busy falls.
    wr(1, 5'd10, 32'hCAFE0001);
    tick();
    idle();
    rdp(0, 5'd10);
    #1;
    expect_v("first_wr", S_RB0, 32'hCAFE0001);
    expect_v("first_wr_nb", S_RN0, 32'hCAFE0001);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
